m_xor_acc: RTL

M_XOR_ACC -- requirements
Module: m_xor_acc

---
 rtl/xor_acc_pkg.sv | 17 +
 rtl/m_xor_word.sv | 21 ++
 rtl/m_xor_acc.sv | 124 ++++++++++++
 3 files changed

// File: rtl/xor_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_acc_pkg
// Description : Shared definitions for the XOR block-checksum accumulator.
//               Holds the FSM state encoding used by m_xor_acc and its bench.
// Contents    : state_e - ACCUM (collecting words) / HOLD (presenting result)
// Revision    : 1.0 - initial release
// ============================================================================
package xor_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage : xor_acc_pkg
`default_nettype wire

// File: rtl/m_xor_word.sv
`default_nettype none
// ============================================================================
// Module      : m_xor_word
// Description : Combinational bitwise XOR of two WIDTH-bit words.
// Ports       : i_a   [WIDTH-1:0] - first operand
//               i_b   [WIDTH-1:0] - second operand
//               o_out [WIDTH-1:0] - i_a ^ i_b
// Revision    : 1.0 - initial release
// ============================================================================
module m_xor_word #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_a ^ i_b;

endmodule : m_xor_word
`default_nettype wire

// File: rtl/m_xor_acc.sv
`default_nettype none
// ============================================================================
// Module      : m_xor_acc
// Description : Folds a stream of words into a bitwise-XOR checksum per block.
//               A block ends after BLOCK_LEN words or on a word flagged with
//               i_last; the result is then held until downstream takes it.
// Ports       : i_clk      - clock, rising edge
//               i_rst_n    - synchronous active-low reset
//               i_clear    - synchronous abort of the current block/result
//               i_valid    - upstream word valid
//               o_ready    - a word is accepted this cycle when i_valid=1
//               i_data     - upstream word [WIDTH-1:0]
//               i_last     - accepted word closes a short block
//               o_valid    - result valid (HOLD state)
//               i_ready    - downstream takes the result
//               o_sum      - running / final XOR of the block [WIDTH-1:0]
//               o_parity   - XOR-reduction of o_sum
//               o_count    - running / final word count [CNT_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module m_xor_acc
  import xor_acc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BLOCK_LEN = 8,
  parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_parity,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] c_block_len = CNT_W'(BLOCK_LEN);

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_acc_xor;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;

  m_xor_word #(
    .WIDTH (WIDTH)
  ) u_xor_word (
    .i_a   (r_acc),
    .i_b   (i_data),
    .o_out (w_acc_xor)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign o_ready   = (r_state == ACCUM) && !i_clear;
  assign w_accept  = i_valid && o_ready;

  // Next-state logic. The clear branch sits above the state decode so it
  // also drops a pending result and any word offered in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    if (i_clear) begin
      w_state_nxt = ACCUM;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            w_acc_nxt = w_acc_xor;
            w_cnt_nxt = w_cnt_inc;
            // A full block and i_last on the same word close one block.
            if ((w_cnt_inc == c_block_len) || i_last) begin
              w_state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (i_ready) begin
            w_state_nxt = ACCUM;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ACCUM;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The accumulator doubles as the result register: in HOLD it is frozen.
  assign o_valid  = (r_state == HOLD);
  assign o_sum    = r_acc;
  assign o_count  = r_cnt;
  assign o_parity = ^r_acc;

endmodule : m_xor_acc
`default_nettype wire
